// File: rtl/math_pkg.sv
// Shared constants and helpers for the power-measurement datapath.
package math_pkg;

    localparam int ACC_WIDTH = 64;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    // True when a full block of full-scale samples cannot exceed ACC_WIDTH bits.
    function automatic bit block_fits(input int data_width, input int log2_len);
        return (2 * data_width - 1 + log2_len) <= 63;
    endfunction

endpackage

// File: rtl/math_cplx_mag2.sv
// Two-stage |x|^2 pipeline: registers I^2 and Q^2, then their sum zero-extended to 64 bits.
module math_cplx_mag2
    import math_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [DATA_WIDTH-1:0] din_q,
    output logic [ACC_WIDTH-1:0]  p,
    output logic                  p_valid
);

    localparam int SQ_W = 2 * DATA_WIDTH;

    logic signed [SQ_W-1:0] ext_i;
    logic signed [SQ_W-1:0] ext_q;
    logic [SQ_W-1:0]        sq_i;
    logic [SQ_W-1:0]        sq_q;
    logic                   s1_valid;
    logic [SQ_W:0]          sum;

    // Sign-extend first so the product is formed at full width.
    assign ext_i = {{DATA_WIDTH{din_i[DATA_WIDTH-1]}}, din_i};
    assign ext_q = {{DATA_WIDTH{din_q[DATA_WIDTH-1]}}, din_q};
    assign sum   = {1'b0, sq_i} + {1'b0, sq_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            p_valid  <= 1'b0;
            sq_i     <= '0;
            sq_q     <= '0;
            p        <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            p_valid  <= 1'b0;
        end else begin
            s1_valid <= din_valid;
            p_valid  <= s1_valid;
            if (din_valid) begin
                sq_i <= $unsigned(ext_i * ext_i);
                sq_q <= $unsigned(ext_q * ext_q);
            end
            if (s1_valid) begin
                p <= {{(ACC_WIDTH - SQ_W - 1){1'b0}}, sum};
            end
        end
    end

endmodule

// File: rtl/math_pwr_integ_64.sv
// Block power integrator: sums I^2+Q^2 over 2^LOG2_LEN samples and emits one
// saturating 64-bit energy word per block.
module math_pwr_integ_64
    import math_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_LEN   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [DATA_WIDTH-1:0] din_q,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  dout_valid,
    output logic                  dout_sat
);

    // Handshake: din_valid is a strobe with no ready; every high cycle is a
    // consumed sample. dout_valid is a one-cycle pulse; downstream never stalls.

    localparam int CNT_W = LOG2_LEN + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((65'd1 << LOG2_LEN) - 65'd1);

    logic [ACC_WIDTH-1:0] p;
    logic                 p_valid;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sat;
    logic [CNT_W-1:0]     count;
    logic [ACC_WIDTH:0]   next_sum;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_sat;

    math_cplx_mag2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mag2 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .din_valid(din_valid),
        .din_i    (din_i),
        .din_q    (din_q),
        .p        (p),
        .p_valid  (p_valid)
    );

    // Saturation is sticky within a block: once clamped, the block stays at max.
    assign next_sum   = {1'b0, acc} + {1'b0, p};
    assign result_sat = next_sum[ACC_WIDTH] | sat;
    assign result     = result_sat ? ACC_MAX : next_sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            sat        <= 1'b0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (clear) begin
                acc   <= '0;
                sat   <= 1'b0;
                count <= '0;
            end else if (p_valid) begin
                if (count == LAST) begin
                    dout       <= result;
                    dout_sat   <= result_sat;
                    dout_valid <= 1'b1;
                    acc        <= '0;
                    sat        <= 1'b0;
                    count      <= '0;
                end else begin
                    acc   <= result;
                    sat   <= result_sat;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_math_pwr_integ_64.sv
// Bench for math_pwr_integ_64: four parameterisations driven side by side, a
// block-level energy model with an expected queue per instance, plus directed sequences.
module tb_math_pwr_integ_64;

    localparam int NDUT = 4;
    localparam int DW [NDUT] = '{16, 16, 31, 16};
    localparam int LL [NDUT] = '{2, 10, 4, 0};
    localparam int W = 97;  // {due edge[31:0], sat, energy[63:0]}

    typedef struct {
        int          si;
        int          sq;
        bit          last;
        logic [63:0] exp_dout;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] di   [NDUT];
    logic [31:0] dq   [NDUT];
    logic        dv   [NDUT];
    logic        clr  [NDUT];
    logic [63:0] dout [NDUT];
    logic        dval [NDUT];
    logic        dsat [NDUT];

    logic [W-1:0] exp_q [NDUT][$];
    logic [127:0] blk_sum [NDUT];
    int           blk_cnt [NDUT];
    int           pulse_cnt [NDUT];
    int           ecnt;
    int           tests;
    int           fails;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    math_pwr_integ_64 #(.DATA_WIDTH(16), .LOG2_LEN(2)) dut_a (
        .clk(clk), .rst(rst), .clear(clr[0]), .din_valid(dv[0]),
        .din_i(di[0][15:0]), .din_q(dq[0][15:0]),
        .dout(dout[0]), .dout_valid(dval[0]), .dout_sat(dsat[0]));

    math_pwr_integ_64 #(.DATA_WIDTH(16), .LOG2_LEN(10)) dut_b (
        .clk(clk), .rst(rst), .clear(clr[1]), .din_valid(dv[1]),
        .din_i(di[1][15:0]), .din_q(dq[1][15:0]),
        .dout(dout[1]), .dout_valid(dval[1]), .dout_sat(dsat[1]));

    math_pwr_integ_64 #(.DATA_WIDTH(31), .LOG2_LEN(4)) dut_c (
        .clk(clk), .rst(rst), .clear(clr[2]), .din_valid(dv[2]),
        .din_i(di[2][30:0]), .din_q(dq[2][30:0]),
        .dout(dout[2]), .dout_valid(dval[2]), .dout_sat(dsat[2]));

    math_pwr_integ_64 #(.DATA_WIDTH(16), .LOG2_LEN(0)) dut_d (
        .clk(clk), .rst(rst), .clear(clr[3]), .din_valid(dv[3]),
        .din_i(di[3][15:0]), .din_q(dq[3][15:0]),
        .dout(dout[3]), .dout_valid(dval[3]), .dout_sat(dsat[3]));

    // ---------------- reference model ----------------
    function automatic longint sample_pwr(input logic [31:0] i, input logic [31:0] q, input int w);
        int si;
        int sq;
        si = int'(i << (32 - w)) >>> (32 - w);
        sq = int'(q << (32 - w)) >>> (32 - w);
        return longint'(si) * longint'(si) + longint'(sq) * longint'(sq);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NDUT; n++) begin
            exp_q[n].delete();
            blk_sum[n] = '0;
            blk_cnt[n] = 0;
        end
    endtask

    // A block completes when 2^LOG2_LEN samples are accepted; its word is due two
    // edges after the last one. A clear wipes the open block and anything not yet out.
    task automatic model_edge();
        logic        sat_b;
        logic [63:0] energy;
        logic [31:0] due;
        for (int n = 0; n < NDUT; n++) begin
            if (clr[n]) begin
                exp_q[n].delete();
                blk_sum[n] = '0;
                blk_cnt[n] = 0;
            end else if (dv[n]) begin
                blk_sum[n] = blk_sum[n] + 128'(sample_pwr(di[n], dq[n], DW[n]));
                blk_cnt[n]++;
                if (blk_cnt[n] == (1 << LL[n])) begin
                    sat_b  = (blk_sum[n][127:64] != 64'd0);
                    energy = sat_b ? 64'hFFFF_FFFF_FFFF_FFFF : blk_sum[n][63:0];
                    due    = 32'(ecnt + 2);
                    exp_q[n].push_back({due, sat_b, energy});
                    blk_sum[n] = '0;
                    blk_cnt[n] = 0;
                end
            end
        end
    endtask

    initial begin
        ecnt = 0;
        model_reset();
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) model_reset();
            else model_edge();
        end
    end

    initial forever begin
        @(posedge rst);
        model_reset();
    end

    // ---------------- scoreboard ----------------
    initial begin
        tests = 0;
        fails = 0;
        for (int n = 0; n < NDUT; n++) pulse_cnt[n] = 0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < NDUT; n++) begin
                logic         exp_v;
                logic [W-1:0] e;
                exp_v = (exp_q[n].size() > 0) && (exp_q[n][0][96:65] == 32'(ecnt));
                if (dval[n]) pulse_cnt[n]++;
                if (exp_v || dval[n]) begin
                    tests++;
                    if (exp_v !== dval[n]) begin
                        fails++;
                        $display("FAIL sb_pulse dut%0d edge %0d: dout_valid=%0b required %0b",
                                 n, ecnt, dval[n], exp_v);
                    end else begin
                        e = exp_q[n][0];
                        tests++;
                        if (dout[n] !== e[63:0] || dsat[n] !== e[64]) begin
                            fails++;
                            $display("FAIL sb_data dut%0d edge %0d: dout=%0h sat=%0b required dout=%0h sat=%0b",
                                     n, ecnt, dout[n], dsat[n], e[63:0], e[64]);
                        end
                    end
                    if (exp_v) void'(exp_q[n].pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input int n, input logic [31:0] i, input logic [31:0] q,
                         input logic v, input logic c);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            dv[k]  = 1'b0;
            clr[k] = 1'b0;
        end
        di[n]  = i;
        dq[n]  = q;
        dv[n]  = v;
        clr[n] = c;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Counts negedges from the last driven sample until dout_valid is seen.
    task automatic wait_pulse(input int n, input int budget, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < budget) begin
            @(negedge clk);
            dv[n]  = 1'b0;
            clr[n] = 1'b0;
            lat++;
            if (dval[n]) got = 1'b1;
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t        vec [16];
    logic [63:0] d_exp [3];

    initial begin
        int          lat;
        int          pc;
        int          np;
        int          first_j;
        int          last_j;
        logic [63:0] seen [3];

        vec[0]  = '{3, 4, 1'b0, 64'd0};
        vec[1]  = '{1, -1, 1'b0, 64'd0};
        vec[2]  = '{0, 0, 1'b0, 64'd0};
        vec[3]  = '{-2, 5, 1'b1, 64'd56};
        vec[4]  = '{-32768, -32768, 1'b0, 64'd0};
        vec[5]  = '{-32768, -32768, 1'b0, 64'd0};
        vec[6]  = '{-32768, -32768, 1'b0, 64'd0};
        vec[7]  = '{-32768, -32768, 1'b1, 64'd8589934592};
        vec[8]  = '{32767, 0, 1'b0, 64'd0};
        vec[9]  = '{0, -32768, 1'b0, 64'd0};
        vec[10] = '{1, 1, 1'b0, 64'd0};
        vec[11] = '{-1, 0, 1'b1, 64'd2147418116};
        vec[12] = '{2, 0, 1'b0, 64'd0};
        vec[13] = '{2, 0, 1'b0, 64'd0};
        vec[14] = '{2, 0, 1'b0, 64'd0};
        vec[15] = '{2, 0, 1'b1, 64'd16};
        d_exp   = '{64'd5, 64'd25, 64'd61};

        rst = 1'b1;
        for (int n = 0; n < NDUT; n++) begin
            di[n] = '0; dq[n] = '0; dv[n] = 1'b0; clr[n] = 1'b0;
        end
        #12;
        for (int n = 0; n < NDUT; n++) begin
            check($sformatf("reset_dout%0d", n), dout[n], 64'd0);
            check($sformatf("reset_valid%0d", n), 64'(dval[n]), 64'd0);
            check($sformatf("reset_sat%0d", n), 64'(dsat[n]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Table: LOG2_LEN=2 blocks driven back-to-back
        for (int t = 0; t < 16; t++) begin
            drive(0, 32'(vec[t].si), 32'(vec[t].sq), 1'b1, 1'b0);
            if (vec[t].last) begin
                wait_pulse(0, 10, lat);
                check($sformatf("tbl_lat%0d", t), 64'(lat), 64'd3);
                check($sformatf("tbl_dout%0d", t), dout[0], vec[t].exp_dout);
                check($sformatf("tbl_sat%0d", t), 64'(dsat[0]), 64'd0);
            end
        end

        // clear coincident with the 4th sample discards the partial block
        pc = pulse_cnt[0];
        for (int k = 0; k < 3; k++) drive(0, 32'd10, 32'd0, 1'b1, 1'b0);
        drive(0, 32'd10, 32'd0, 1'b1, 1'b1);
        drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("clr_hold_dout", dout[0], 64'd16);
        check("clr_no_pulse", 64'(dval[0]), 64'd0);
        for (int k = 0; k < 4; k++) drive(0, 32'd1, 32'd1, 1'b1, 1'b0);
        wait_pulse(0, 10, lat);
        check("clr_lat", 64'(lat), 64'd3);
        check("clr_dout", dout[0], 64'd8);
        idle(3);
        check("clr_pulses", 64'(pulse_cnt[0] - pc), 64'd1);

        // LOG2_LEN=10 full-scale block with gaps, then a random block straight after
        pc = pulse_cnt[1];
        fork
            begin
                for (int k = 0; k < 1024; k++) begin
                    if ($urandom_range(0, 3) == 0) drive(1, 32'd0, 32'd0, 1'b0, 1'b0);
                    drive(1, 32'hFFFF_8000, 32'hFFFF_8000, 1'b1, 1'b0);
                end
                for (int k = 0; k < 1024; k++) begin
                    if ($urandom_range(0, 4) == 0) drive(1, 32'd0, 32'd0, 1'b0, 1'b0);
                    drive(1, $urandom(), $urandom(), 1'b1, 1'b0);
                end
            end
            begin
                bit got_b;
                got_b = 1'b0;
                for (int k = 0; k < 4000 && !got_b; k++) begin
                    @(negedge clk);
                    if (dval[1]) got_b = 1'b1;
                end
                check("b_got", 64'(got_b), 64'd1);
                check("b_dout", dout[1], 64'd1 << 41);
                check("b_sat", 64'(dsat[1]), 64'd0);
            end
        join
        wait_pulse(1, 10, lat);
        check("b_lat2", 64'(lat), 64'd3);
        check("b_pulses", 64'(pulse_cnt[1] - pc), 64'd2);

        // DATA_WIDTH=31 overflow then a clean block
        for (int k = 0; k < 16; k++) drive(2, 32'hC000_0000, 32'hC000_0000, 1'b1, 1'b0);
        wait_pulse(2, 10, lat);
        check("c_sat_lat", 64'(lat), 64'd3);
        check("c_sat_dout", dout[2], 64'hFFFF_FFFF_FFFF_FFFF);
        check("c_sat_flag", 64'(dsat[2]), 64'd1);
        for (int k = 0; k < 16; k++) drive(2, 32'd1, 32'd0, 1'b1, 1'b0);
        wait_pulse(2, 10, lat);
        check("c_clean_dout", dout[2], 64'd16);
        check("c_clean_flag", 64'(dsat[2]), 64'd0);

        // LOG2_LEN=0: every sample is a block
        drive(3, 32'd1, 32'd2, 1'b1, 1'b0);
        drive(3, 32'd3, 32'd4, 1'b1, 1'b0);
        drive(3, 32'd5, 32'd6, 1'b1, 1'b0);
        np = 0; first_j = -1; last_j = -1;
        for (int k = 0; k < 3; k++) seen[k] = '1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            dv[3] = 1'b0;
            if (dval[3]) begin
                if (np < 3) seen[np] = dout[3];
                if (first_j < 0) first_j = j;
                last_j = j;
                np++;
            end
        end
        check("d_count", 64'(np), 64'd3);
        check("d_first", 64'(first_j), 64'd0);
        check("d_last", 64'(last_j), 64'd2);
        for (int k = 0; k < 3; k++) check($sformatf("d_val%0d", k), seen[k], d_exp[k]);

        // Random streams with occasional clears on every instance
        for (int n = 0; n < NDUT; n++) begin
            for (int k = 0; k < 300; k++) begin
                drive(n, $urandom(), $urandom(), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 49) == 0));
            end
            idle(5);
        end
        for (int n = 0; n < NDUT; n++)
            check($sformatf("drain%0d", n), 64'(exp_q[n].size()), 64'd0);

        // Asynchronous reset mid-block
        drive(0, 32'd5, 32'd5, 1'b1, 1'b0);
        drive(0, 32'd5, 32'd5, 1'b1, 1'b0);
        drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int n = 0; n < NDUT; n++) begin
            check($sformatf("rst_dout%0d", n), dout[n], 64'd0);
            check($sformatf("rst_valid%0d", n), 64'(dval[n]), 64'd0);
            check($sformatf("rst_sat%0d", n), 64'(dsat[n]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(0, 32'd2, 32'd0, 1'b1, 1'b0);
        wait_pulse(0, 10, lat);
        check("rst_after_lat", 64'(lat), 64'd3);
        check("rst_after_dout", dout[0], 64'd16);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
